// File: rtl/i2s_sched_pkg.sv
// Shared codes for the I2S channel scheduler: host mode requests, selector codes,
// handshake states and the round-robin step order.
package i2s_sched_pkg;

  typedef enum logic [1:0] {
    MODE_CH1 = 2'd0,
    MODE_CH2 = 2'd1,
    MODE_MIX = 2'd2,
    MODE_RR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_PEND = 2'd1,
    HS_DONE = 2'd2
  } hs_state_e;

  localparam logic [1:0] SEL_CH1 = 2'd0;
  localparam logic [1:0] SEL_CH2 = 2'd1;
  localparam logic [1:0] SEL_MIX = 2'd2;

  // Round-robin order CH1 -> CH2 -> MIX -> CH1; code 3 is never produced.
  function automatic logic [1:0] rr_step(input logic [1:0] sel);
    logic [1:0] nxt;
    case (sel)
      SEL_CH1: nxt = SEL_CH2;
      SEL_CH2: nxt = SEL_MIX;
      default: nxt = SEL_CH1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Bit-slot counter and word-select generator; flags the frame boundary edge and
// decodes frame_start from registered state.
module i2s_frame_timer #(
  parameter int WORD_BITS = 16,
  parameter int CNT_W     = $clog2(WORD_BITS)
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             enable,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             ws,
  output logic             boundary,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic slot_end;

  assign slot_end    = enable && (bit_cnt == LAST_BIT);
  // The frame ends on the last bit of the ws=1 slot.
  assign boundary    = slot_end && ws;
  assign frame_start = enable && (bit_cnt == '0) && !ws;

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else if (enable) begin
      if (slot_end) begin
        bit_cnt <= '0;
        ws      <= ~ws;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_channel_scheduler.sv
// Frame sequencer for the two-channel I2S selector: accepts host mode changes and
// updates channel_sel only on frame boundaries, auto-rotating in round-robin mode.
//
// Handshake FSM
//   state   | meaning
//   HS_IDLE | no request held, mode_ready=1
//   HS_PEND | request stored, waiting for the next frame boundary
//   HS_DONE | request applied this edge; ready returns next cycle
module i2s_channel_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int WORD_BITS  = 16,
  parameter int ROT_FRAMES = 2
) (
  input  logic                         sck,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [1:0]                   mode_req,
  input  logic                         mode_valid,
  output logic                         mode_ready,
  output logic                         ws,
  output logic [1:0]                   channel_sel,
  output logic                         frame_start,
  output logic [$clog2(WORD_BITS)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(WORD_BITS);
  localparam int FC_W  = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(ROT_FRAMES - 1);

  hs_state_e       hs_state;
  hs_state_e       hs_next;
  mode_e           pend_mode;
  mode_e           cur_mode;
  mode_e           next_mode;
  logic [FC_W-1:0] frame_cnt;
  logic            boundary;
  logic            accept;
  logic            apply;

  i2s_frame_timer #(
    .WORD_BITS (WORD_BITS),
    .CNT_W     (CNT_W)
  ) u_timer (
    .sck         (sck),
    .rst         (rst),
    .enable      (enable),
    .bit_cnt     (bit_cnt),
    .ws          (ws),
    .boundary    (boundary),
    .frame_start (frame_start)
  );

  assign accept    = mode_valid && mode_ready;
  // A request stored on a boundary edge is only seen as pending from the next
  // cycle on, so it naturally waits for the following boundary.
  assign apply     = boundary && (hs_state == HS_PEND);
  assign next_mode = apply ? pend_mode : cur_mode;

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      hs_state <= HS_IDLE;
    end else begin
      hs_state <= hs_next;
    end
  end

  always_comb begin
    hs_next    = hs_state;
    mode_ready = 1'b0;
    case (hs_state)
      HS_IDLE: begin
        mode_ready = 1'b1;
        if (mode_valid) begin
          hs_next = HS_PEND;
        end
      end
      HS_PEND: begin
        if (boundary) begin
          hs_next = HS_DONE;
        end
      end
      HS_DONE: hs_next = HS_IDLE;
      default: hs_next = HS_IDLE;
    endcase
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      pend_mode <= MODE_CH1;
    end else if (accept) begin
      pend_mode <= mode_e'(mode_req);
    end
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      cur_mode    <= MODE_CH1;
      channel_sel <= SEL_CH1;
      frame_cnt   <= '0;
    end else if (boundary) begin
      cur_mode <= next_mode;
      if (next_mode != MODE_RR) begin
        channel_sel <= next_mode;
        frame_cnt   <= '0;
      end else if (cur_mode != MODE_RR) begin
        channel_sel <= SEL_CH1;
        frame_cnt   <= '0;
      end else if (frame_cnt == LAST_FRAME) begin
        // Re-requesting RR lands here too, so rotation continues undisturbed.
        channel_sel <= rr_step(channel_sel);
        frame_cnt   <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_channel_scheduler.sv
// Bench for i2s_channel_scheduler: table vectors for basic framing and handshake,
// then hand sequences for boundary accept, pause, round-robin and async reset.
module tb_i2s_channel_scheduler;

  logic       sck = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       mode_ready;
  logic       ws;
  logic [1:0] channel_sel;
  logic       frame_start;
  logic [3:0] bit_cnt;

  i2s_channel_scheduler #(
    .WORD_BITS  (16),
    .ROT_FRAMES (2)
  ) dut (
    .sck         (sck),
    .rst         (rst),
    .enable      (enable),
    .mode_req    (mode_req),
    .mode_valid  (mode_valid),
    .mode_ready  (mode_ready),
    .ws          (ws),
    .channel_sel (channel_sel),
    .frame_start (frame_start),
    .bit_cnt     (bit_cnt)
  );

  always #5 sck = ~sck;

  typedef struct {
    logic       en;
    logic [1:0] req;
    logic       val;
    logic       ews;
    logic [3:0] ebit;
    logic       efs;
    logic [1:0] esel;
    logic       erdy;
  } vec_t;

  typedef struct {
    int         tag;
    logic [8:0] exp;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[64];
  int    n_cmp = 0;
  int    n_err = 0;
  int    tcyc  = 0;
  string phase_name = "init";
  int    rr_exp[9] = '{0, 0, 1, 1, 2, 2, 0, 0, 1};

  task automatic score();
    exp_t       e;
    logic [8:0] act;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard empty at compare", phase_name);
      return;
    end
    e   = sb.pop_front();
    act = {ws, bit_cnt, frame_start, channel_sel, mode_ready};
    n_cmp++;
    if (act !== e.exp || channel_sel == 2'd3) begin
      n_err++;
      $display("FAIL %s t%0d got ws=%b bit=%0d fs=%b sel=%0d rdy=%b want ws=%b bit=%0d fs=%b sel=%0d rdy=%b",
               phase_name, e.tag, act[8], act[7:4], act[3], act[2:1], act[0],
               e.exp[8], e.exp[7:4], e.exp[3], e.exp[2:1], e.exp[0]);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    enable     = v.en;
    mode_req   = v.req;
    mode_valid = v.val;
    e.tag      = tcyc;
    e.exp      = {v.ews, v.ebit, v.efs, v.esel, v.erdy};
    sb.push_back(e);
    @(negedge sck);
    score();
    @(posedge sck);
    if (v.en) tcyc++;
    #1;
  endtask

  // Slot timing follows from the count of enabled edges since reset.
  task automatic cyc(input logic en, input logic [1:0] req, input logic val,
                     input logic [1:0] esel, input logic erdy);
    vec_t v;
    v.en   = en;
    v.req  = req;
    v.val  = val;
    v.ews  = 1'((tcyc / 16) % 2);
    v.ebit = 4'(tcyc % 16);
    v.efs  = en && ((tcyc % 32) == 0);
    v.esel = esel;
    v.erdy = erdy;
    apply_vec(v);
  endtask

  task automatic check_reset(input string name);
    logic [8:0] act;
    logic [8:0] exp;
    act = {ws, bit_cnt, frame_start, channel_sel, mode_ready};
    exp = {1'b0, 4'h0, enable, 2'd0, 1'b1};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got ws=%b bit=%0d fs=%b sel=%0d rdy=%b want ws=%b bit=%0d fs=%b sel=%0d rdy=%b",
               name, act[8], act[7:4], act[3], act[2:1], act[0],
               exp[8], exp[7:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired in phase %s", phase_name);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] req;
    logic       val;
    logic [1:0] esel;
    logic       erdy;

    for (int i = 0; i < 64; i++) begin
      vecs[i].en   = 1'b1;
      vecs[i].req  = 2'd1;
      vecs[i].val  = (i == 5);
      vecs[i].ews  = 1'((i / 16) % 2);
      vecs[i].ebit = 4'(i % 16);
      vecs[i].efs  = ((i % 32) == 0);
      vecs[i].esel = (i >= 32) ? 2'd1 : 2'd0;
      vecs[i].erdy = !(i >= 6 && i <= 32);
    end

    rst        = 1'b0;
    enable     = 1'b1;
    mode_req   = 2'd0;
    mode_valid = 1'b0;
    #12;
    check_reset("reset_en1");
    enable = 1'b0;
    #1;
    check_reset("reset_en0");
    enable = 1'b1;
    #1;
    check_reset("reset_en1_again");
    @(posedge sck);
    #1;
    rst  = 1'b1;
    tcyc = 0;

    phase_name = "frame_and_ch2_request";
    for (int i = 0; i < 64; i++) apply_vec(vecs[i]);

    phase_name = "accept_on_boundary";
    while (tcyc < 130)
      cyc(1'b1, 2'd2, tcyc == 95, (tcyc >= 128) ? 2'd2 : 2'd1, !(tcyc >= 96 && tcyc <= 128));

    phase_name = "enable_pause";
    while (tcyc < 135) cyc(1'b1, 2'd0, 1'b0, 2'd2, 1'b1);
    for (int p = 0; p < 10; p++) cyc(1'b0, 2'd0, p == 3, 2'd2, p <= 3);
    while (tcyc < 162) cyc(1'b1, 2'd0, 1'b0, (tcyc >= 160) ? 2'd0 : 2'd2, tcyc >= 161);

    phase_name = "round_robin";
    while (tcyc < 457) begin
      req  = (tcyc == 300) ? 2'd1 : ((tcyc == 450) ? 2'd2 : 2'd3);
      val  = (tcyc == 162) || (tcyc == 293) || (tcyc == 300) || (tcyc == 450);
      esel = (tcyc < 192) ? 2'd0 : 2'(rr_exp[(tcyc - 192) / 32]);
      erdy = !((tcyc >= 163 && tcyc <= 192) || (tcyc >= 294 && tcyc <= 320) || tcyc >= 451);
      cyc(1'b1, req, val, esel, erdy);
    end

    phase_name = "async_reset";
    mode_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset("async_reset_mid_frame");
    @(posedge sck);
    @(posedge sck);
    #1;
    check_reset("reset_held");
    rst  = 1'b1;
    tcyc = 0;

    phase_name = "after_reset";
    while (tcyc < 70) cyc(1'b1, 2'd0, 1'b0, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
